// File: rtl/pll_trim_ctrl.sv
// pll_trim_ctrl: power-up sequencer and trim auto-calibration for avsdpll_1v8.
// Enables CP, then VCO, sweeps trim for the feedback count closest to target, then tracks lock.
module pll_trim_ctrl #(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned WIN_CYC    = 1024,
    parameter int unsigned CP_SETTLE  = 64,
    parameter int unsigned VCO_SETTLE = 256,
    parameter int unsigned MISS_MAX   = 3
) (
    input  logic             ref_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fb_tgl,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] tol,
    output logic             en_cp_n,
    output logic             en_vco_n,
    output logic [3:0]       trim,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic [CNT_W-1:0] last_cnt
);

    localparam int unsigned TMR_MAX = (CP_SETTLE > VCO_SETTLE) ? CP_SETTLE : VCO_SETTLE;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned WIN_W   = $clog2(WIN_CYC + 1);
    localparam int unsigned MISS_W  = $clog2(MISS_MAX + 1);

    localparam logic [TMR_W-1:0]  CP_LAST   = TMR_W'(CP_SETTLE - 1);
    localparam logic [TMR_W-1:0]  VCO_LAST  = TMR_W'(VCO_SETTLE - 1);
    localparam logic [WIN_W-1:0]  WIN_END   = WIN_W'(WIN_CYC);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, CP_ON, VCO_ON, SETTLE, MEAS, DECIDE, LOCKED, FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sync_q;
    logic [TMR_W-1:0]  tmr_q;
    logic [WIN_W-1:0]  win_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [3:0]        code_q;
    logic [3:0]        best_code_q;
    logic [CNT_W-1:0]  best_err_q;
    logic [MISS_W-1:0] miss_q;

    logic             fb_edge;
    logic             timed;
    logic             in_window;
    logic             counting;
    logic             win_done;
    logic [CNT_W-1:0] err;
    logic             out_of_tol;
    logic             lose_lock;
    logic             sweep_eval;
    logic             sweep_start;

    // Window = WIN_CYC counting cycles followed by one evaluation cycle.
    assign fb_edge     = sync_q[1] ^ sync_q[2];
    assign timed       = (state_q == CP_ON) || (state_q == VCO_ON) || (state_q == SETTLE);
    assign in_window   = (state_q == MEAS) || (state_q == LOCKED);
    assign counting    = in_window && (win_q != WIN_END);
    assign win_done    = in_window && (win_q == WIN_END);
    assign err         = (cnt_q >= target) ? (cnt_q - target) : (target - cnt_q);
    assign out_of_tol  = err > tol;
    assign lose_lock   = (state_q == LOCKED) && win_done && out_of_tol && (miss_q == MISS_LAST);
    assign sweep_eval  = (state_q == MEAS) && win_done && enable;
    assign sweep_start = ((state_q == VCO_ON) && (state_d == MEAS)) || (lose_lock && enable);

    always_comb begin
        state_d  = state_q;
        en_cp_n  = 1'b1;
        en_vco_n = 1'b1;
        busy     = 1'b0;
        locked   = 1'b0;
        fail     = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = CP_ON;
            CP_ON: begin
                en_cp_n = 1'b0;
                busy    = 1'b1;
                if (tmr_q == CP_LAST) state_d = VCO_ON;
            end
            VCO_ON, SETTLE: begin
                en_cp_n  = 1'b0;
                en_vco_n = 1'b0;
                busy     = 1'b1;
                if (tmr_q == VCO_LAST) state_d = MEAS;
            end
            MEAS: begin
                en_cp_n  = 1'b0;
                en_vco_n = 1'b0;
                busy     = 1'b1;
                if (win_done) state_d = (code_q == 4'd15) ? DECIDE : SETTLE;
            end
            DECIDE: begin
                en_cp_n  = 1'b0;
                en_vco_n = 1'b0;
                busy     = 1'b1;
                state_d  = (best_err_q <= tol) ? LOCKED : FAIL;
            end
            LOCKED: begin
                en_cp_n  = 1'b0;
                en_vco_n = 1'b0;
                locked   = !lose_lock;
                if (lose_lock) state_d = SETTLE;
            end
            FAIL: begin
                en_cp_n  = 1'b0;
                en_vco_n = 1'b0;
                fail     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) state_d = IDLE;
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            tmr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            last_cnt    <= '0;
            code_q      <= '0;
            trim        <= '0;
            best_code_q <= '0;
            best_err_q  <= '1;
            miss_q      <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[1:0], fb_tgl};

            if (state_d != state_q)  tmr_q <= '0;
            else if (timed)          tmr_q <= tmr_q + 1'b1;

            if (state_d != state_q || win_done) win_q <= '0;
            else if (counting)                  win_q <= win_q + 1'b1;

            if (!counting)                    cnt_q <= '0;
            else if (fb_edge && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;

            if (win_done) last_cnt <= cnt_q;

            // Strict < keeps the lower code on a tie.
            if (sweep_eval) begin
                if (err < best_err_q) begin
                    best_err_q  <= err;
                    best_code_q <= code_q;
                end
                if (code_q != 4'd15) begin
                    code_q <= code_q + 1'b1;
                    trim   <= code_q + 1'b1;
                end
            end

            if (sweep_start) begin
                code_q      <= '0;
                trim        <= '0;
                best_err_q  <= '1;
                best_code_q <= '0;
            end

            if (state_q == DECIDE && enable) begin
                trim   <= best_code_q;
                miss_q <= '0;
            end

            if (state_q == LOCKED && win_done)
                miss_q <= (out_of_tol && !lose_lock) ? miss_q + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_pll_trim_ctrl.sv
// tb_pll_trim_ctrl: drives a trim-dependent feedback model and scoreboards each sweep window count.
module tb_pll_trim_ctrl;

    logic        ref_clk = 1'b0;
    logic        rst     = 1'b1;
    logic        enable  = 1'b0;
    logic        fb_tgl  = 1'b0;
    logic [11:0] target  = 12'd500;
    logic [11:0] tol     = 12'd10;
    logic        en_cp_n, en_vco_n, busy, locked, fail;
    logic [3:0]  trim;
    logic [11:0] last_cnt;

    pll_trim_ctrl #(
        .CNT_W(12), .WIN_CYC(1024), .CP_SETTLE(64), .VCO_SETTLE(256), .MISS_MAX(3)
    ) dut (
        .ref_clk(ref_clk), .rst(rst), .enable(enable), .fb_tgl(fb_tgl),
        .target(target), .tol(tol), .en_cp_n(en_cp_n), .en_vco_n(en_vco_n),
        .trim(trim), .busy(busy), .locked(locked), .fail(fail), .last_cnt(last_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    int unsigned tab [16];
    int unsigned force_n = 0;
    int unsigned acc = 0;
    int unsigned exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          t = 0;

    // PLL model: exactly N toggles in any 1024 consecutive ref cycles, N chosen by trim.
    initial begin
        forever begin
            @(negedge ref_clk);
            acc = acc + ((force_n != 0) ? force_n : tab[trim]);
            if (acc >= 1024) begin
                acc    = acc - 1024;
                fb_tgl = ~fb_tgl;
            end
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge ref_clk);
        t += n;
    endtask

    task automatic wait_to(input int idx);
        step(idx - t);
    endtask

    // Index 0 is the negedge after the first edge that samples enable=1.
    task automatic start_run();
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge ref_clk);
        rst = 1'b0;
        repeat (2) @(negedge ref_clk);
        enable = 1'b1;
        @(negedge ref_clk);
        t = 0;
    endtask

    task automatic sweep_check(input string name);
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(tab[k]);
            wait_to(1345 + 1281 * k);
            check($sformatf("%s_cnt%0d", name, k), last_cnt, exp_q.pop_front());
            if (k < 15) check($sformatf("%s_trim%0d", name, k), trim, k + 1);
        end
        wait_to(20560);
        check({name, "_decide_busy"}, busy, 1);
        check({name, "_decide_locked"}, locked, 0);
        wait_to(20561);
    endtask

    initial begin
        // Run A: startup timing, nominal lock, lock-loss handling, enable drop.
        for (int k = 0; k < 16; k++) tab[k] = 40 * k + 100;
        target = 12'd500;
        tol    = 12'd10;
        rst    = 1'b1;
        repeat (3) @(negedge ref_clk);
        check("rst_en_cp_n", en_cp_n, 1);
        check("rst_en_vco_n", en_vco_n, 1);
        check("rst_trim", trim, 0);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail, 0);
        check("rst_last_cnt", last_cnt, 0);
        start_run();
        check("t1_cp_on", en_cp_n, 0);
        check("t1_vco_off", en_vco_n, 1);
        check("t1_busy", busy, 1);
        wait_to(63);
        check("t1_vco_still_off", en_vco_n, 1);
        wait_to(64);
        check("t1_vco_on", en_vco_n, 0);
        wait_to(1344);
        check("t1_win_not_done", last_cnt, 0);
        sweep_check("t2");
        check("t2_locked", locked, 1);
        check("t2_trim", trim, 10);
        check("t2_busy", busy, 0);

        for (int w = 0; w < 6; w++) begin
            force_n = (w == 2) ? 0 : 700;
            step(1024);
            check($sformatf("t5_eval_locked%0d", w), locked, (w == 5) ? 0 : 1);
            step(1);
        end
        force_n = 0;
        check("t5_relock_locked", locked, 0);
        check("t5_restart_trim", trim, 0);
        check("t5_restart_busy", busy, 1);
        check("t5_cp_kept", en_cp_n, 0);
        check("t5_vco_kept", en_vco_n, 0);

        wait_to(27200);
        check("t6_meas_busy", busy, 1);
        enable = 1'b0;
        step(1);
        check("t6_en_cp_n", en_cp_n, 1);
        check("t6_en_vco_n", en_vco_n, 1);
        check("t6_busy", busy, 0);
        check("t6_locked", locked, 0);

        // Run B: equal error on codes 9 and 11 keeps the lower code.
        for (int k = 0; k < 16; k++) tab[k] = 700 + 20 * k;
        tab[9]  = 490;
        tab[11] = 510;
        start_run();
        sweep_check("t3");
        check("t3_locked", locked, 1);
        check("t3_trim", trim, 9);

        // Run C: no code within tolerance; best is code 15 (count 600).
        for (int k = 0; k < 16; k++) tab[k] = 975 - 25 * k;
        start_run();
        sweep_check("t4");
        check("t4_fail", fail, 1);
        check("t4_locked", locked, 0);
        check("t4_busy", busy, 0);
        check("t4_trim", trim, 15);
        check("t4_en_cp_n", en_cp_n, 0);
        check("t4_en_vco_n", en_vco_n, 0);
        step(200);
        check("t4_fail_sticky", fail, 1);
        enable = 1'b0;
        step(1);
        check("t4_fail_clear", fail, 0);
        check("t4_idle_cp", en_cp_n, 1);
        check("t4_trim_hold", trim, 15);

        // Run D: reset mid-window with enable still high.
        for (int k = 0; k < 16; k++) tab[k] = 40 * k + 100;
        start_run();
        wait_to(2000);
        check("t6r_pre_trim", trim, 1);
        check("t6r_pre_cnt", last_cnt, 100);
        rst = 1'b1;
        step(1);
        check("t6r_en_cp_n", en_cp_n, 1);
        check("t6r_en_vco_n", en_vco_n, 1);
        check("t6r_trim", trim, 0);
        check("t6r_busy", busy, 0);
        check("t6r_locked", locked, 0);
        check("t6r_fail", fail, 0);
        check("t6r_last_cnt", last_cnt, 0);
        rst = 1'b0;
        step(1);
        check("t6r_restart_cp", en_cp_n, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
